// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM and its surroundings (packet source, FIFOs, register stage).
// master = the FSM, which drives the strobes; slave = the environment, which supplies status.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       write_enb_reg;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_packet_valid,
        output write_enb_reg, detect_add, lfd_state, ld_state,
        output laf_state, full_state, rst_int_reg, busy
    );

    modport slave (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_packet_valid,
        input  write_enb_reg, detect_add, lfd_state, ld_state,
        input  laf_state, full_state, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, then sequences header/payload/parity loads.
// Moore outputs, one state per cycle; busy holds the source off everywhere except DA and LD.
module router_fsm (
    input  logic          clock,
    input  logic          resetn,
    router_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        FFS = 3'd3,
        LAF = 3'd4,
        LP  = 3'd5,
        CPE = 3'd6,
        WTE = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;
    logic [1:0] w_next_addr;
    logic       w_hdr_empty;
    logic       w_sel_empty;
    logic       w_sel_soft;

    // Per-port status muxes; address 3 is never stored, so it selects nothing.
    always_comb begin
        w_hdr_empty = 1'b0;
        w_sel_empty = 1'b0;
        w_sel_soft  = 1'b0;
        case (bus.data_in)
            2'd0:    w_hdr_empty = bus.fifo_empty_0;
            2'd1:    w_hdr_empty = bus.fifo_empty_1;
            2'd2:    w_hdr_empty = bus.fifo_empty_2;
            default: w_hdr_empty = 1'b0;
        endcase
        case (r_addr)
            2'd0:    begin w_sel_empty = bus.fifo_empty_0; w_sel_soft = bus.soft_reset_0; end
            2'd1:    begin w_sel_empty = bus.fifo_empty_1; w_sel_soft = bus.soft_reset_1; end
            2'd2:    begin w_sel_empty = bus.fifo_empty_2; w_sel_soft = bus.soft_reset_2; end
            default: begin w_sel_empty = 1'b0;             w_sel_soft = 1'b0;             end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DA;
            r_addr  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        case (r_state)
            DA: begin
                if (bus.pkt_valid && (bus.data_in != 2'd3)) begin
                    w_next_addr  = bus.data_in;
                    w_next_state = w_hdr_empty ? LFD : WTE;
                end
            end
            LFD: w_next_state = LD;
            LD: begin
                if (bus.fifo_full)       w_next_state = FFS;
                else if (!bus.pkt_valid) w_next_state = LP;
            end
            FFS: begin
                if (!bus.fifo_full) w_next_state = LAF;
            end
            LAF: begin
                if (bus.parity_done)           w_next_state = DA;
                else if (bus.low_packet_valid) w_next_state = LP;
                else                           w_next_state = LD;
            end
            LP:  w_next_state = CPE;
            CPE: w_next_state = bus.fifo_full ? FFS : DA;
            WTE: begin
                if (w_sel_empty) w_next_state = LFD;
            end
            default: w_next_state = DA;
        endcase
        // A timeout on the selected port abandons the packet from any busy state.
        if ((r_state != DA) && w_sel_soft) w_next_state = DA;
    end

    assign bus.detect_add    = (r_state == DA);
    assign bus.lfd_state     = (r_state == LFD);
    assign bus.ld_state      = (r_state == LD);
    assign bus.laf_state     = (r_state == LAF);
    assign bus.full_state    = (r_state == FFS);
    assign bus.rst_int_reg   = (r_state == CPE);
    assign bus.write_enb_reg = (r_state == LD) || (r_state == LP) || (r_state == LAF);
    assign bus.busy          = (r_state != DA) && (r_state != LD);
endmodule
